// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end.
// It owns the fetch PC and issues sequential word reads to instruction memory.
// Returned words are buffered with their PCs in a first-word-fall-through FIFO,
// and decode drains them through a valid/ready handshake.
// A redirect flushes all wrong-path state.
// Optional feature: define FETCHQ_BYPASS_EN to let a response arriving at an
// empty queue reach decode in the same cycle it arrives.
module fetch_queue #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(32'h0100_0000)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req_o,
    output logic [AWIDTH-1:0]          imem_addr_o,
    input  logic [DWIDTH-1:0]          imem_data_i,
    input  logic                       redirect_i,
    input  logic [AWIDTH-1:0]          redirect_pc_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DWIDTH-1:0]          insn_o,
    output logic [AWIDTH-1:0]          pc_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW:0]       DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]     CNT_ONE = CW'(1);
    localparam logic [PW-1:0]     PTR_ONE = PW'(1);
    localparam logic [AWIDTH-1:0] PC_STEP = AWIDTH'(4);

    // Fetch PC and the single outstanding request
    logic [AWIDTH-1:0] fetch_pc;
    logic              inflight;
    logic [AWIDTH-1:0] inflight_pc;

    // Circular buffer state
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_n;
    logic [DWIDTH-1:0] insn_mem [DEPTH];
    logic [AWIDTH-1:0] pc_mem   [DEPTH];

    // Per-cycle control decisions
    logic [CW:0] credit;
    logic        issue;
    logic        rsp_live;
    logic        fifo_nonempty;
    logic        bypass_hit;
    logic        push_fifo;
    logic        pop_fifo;

    // Issue, response and pop decisions for this cycle
    always_comb begin
        credit        = {1'b0, count} + {{CW{1'b0}}, inflight};
        fifo_nonempty = (count != '0);
        // Occupied slots plus the outstanding request must stay below DEPTH,
        // so every response that comes back is guaranteed a free slot.
        issue         = !rst && !redirect_i && (credit < DEPTH_W);
        // A response in a reset or redirect cycle belongs to the old path.
        rsp_live      = inflight && !rst && !redirect_i;
`ifdef FETCHQ_BYPASS_EN
        bypass_hit    = rsp_live && !fifo_nonempty;
        push_fifo     = rsp_live && !(bypass_hit && ready_i);
`else
        bypass_hit    = 1'b0;
        push_fifo     = rsp_live;
`endif
        pop_fifo      = fifo_nonempty && ready_i && !rst && !redirect_i;
    end

    // Occupancy after this cycle's push and pop
    always_comb begin
        count_n = count;
        unique case ({push_fifo, pop_fifo})
            2'b10:   count_n = count + CNT_ONE;
            2'b01:   count_n = count - CNT_ONE;
            default: count_n = count;
        endcase
    end

    // Output drive: memory request plus the head entry, or the bypassed response
    always_comb begin
        imem_req_o  = issue;
        imem_addr_o = fetch_pc;
        valid_o     = !rst && (fifo_nonempty || bypass_hit);
        count_o     = rst ? '0 : count;
        insn_o      = '0;
        pc_o        = '0;
        if (!rst) begin
            if (fifo_nonempty) begin
                insn_o = insn_mem[head];
                pc_o   = pc_mem[head];
            end else if (bypass_hit) begin
                insn_o = imem_data_i;
                pc_o   = inflight_pc;
            end
        end
    end

    // Control state: fetch PC, in-flight flag, pointers and count
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            // Force word alignment; clearing inflight kills any outstanding response.
            fetch_pc <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            inflight <= issue;
            if (push_fifo) begin
                tail <= tail + PTR_ONE;
            end
            if (pop_fifo) begin
                head <= head + PTR_ONE;
            end
            count <= count_n;
        end
    end

    // Remember which PC the outstanding request was for
    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= fetch_pc;
        end
    end

    // FIFO payload write at the tail
    always_ff @(posedge clk) begin
        if (push_fifo) begin
            insn_mem[tail] <= imem_data_i;
            pc_mem[tail]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue.
// A memory model returns addr ^ 32'hA5A5_A5A5 one cycle after each request.
// Expected PCs and instructions are derived from that rule.
// When no request was made, the memory model returns 32'hDEAD_BEEF.
module tb_fetch_queue;

    localparam logic [31:0] RPC = 32'h0100_0000;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;
`ifdef FETCHQ_BYPASS_EN
    localparam int          FIRST      = 1;
    localparam logic [2:0]  STREAM_CNT = 3'd0;
`else
    localparam int          FIRST      = 2;
    localparam logic [2:0]  STREAM_CNT = 3'd1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ready = 1'b0;
    logic [31:0] imem_data = 32'hDEAD_BEEF;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        valid;
    logic [31:0] insn;
    logic [31:0] pc;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_queue dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .valid_o       (valid),
        .ready_i       (ready),
        .insn_o        (insn),
        .pc_o          (pc),
        .count_o       (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_data <= imem_req ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic v, input logic [31:0] epc);
        check({tag, ".valid"}, valid, v);
        if (v) begin
            check({tag, ".pc"}, pc, epc);
            check({tag, ".insn"}, insn, epc ^ KEY);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, checked inside a reset cycle
        rst = 1'b1;
        ready = 1'b1;
        step();
        step();
        #1;
        check("rst.req", imem_req, 1'b0);
        check("rst.valid", valid, 1'b0);
        check("rst.count", count, 3'd0);
        check("rst.insn", insn, 32'h0);
        check("rst.pc", pc, 32'h0);
        step();

        // Streaming with ready held high
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("s1.req%0d", k), imem_req, 1'b1);
            check($sformatf("s1.addr%0d", k), imem_addr, RPC + 32'(4 * k));
            expect_head($sformatf("s1.c%0d", k), k >= FIRST, RPC + 32'(4 * (k - FIRST)));
            if (k >= FIRST) check($sformatf("s1.cnt%0d", k), count, STREAM_CNT);
            step();
        end

        // Backpressure: decode stalls for 10 cycles
        ready = 1'b0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("bp.req%0d", k), imem_req, k < 4);
            if (k < 4) check($sformatf("bp.addr%0d", k), imem_addr, RPC + 32'(4 * k));
            check($sformatf("bp.cnt%0d", k), count, (k < 1) ? 3'd0 : ((k > 5) ? 3'd4 : 3'(k - 1)));
            expect_head($sformatf("bp.c%0d", k), k >= FIRST, RPC);
            step();
        end
        ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            #1;
            expect_head($sformatf("dr.c%0d", j), 1'b1, RPC + 32'(4 * j));
            if (j == 0) begin
                check("dr.cnt0", count, 3'd4);
                check("dr.req0", imem_req, 1'b0);
            end
            if (j == 1) begin
                check("dr.req1", imem_req, 1'b1);
                check("dr.addr1", imem_addr, 32'h0100_0010);
            end
            step();
        end

        // Redirect while a request is in flight and three entries are queued
        ready = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) step();
        #1;
        check("rd.precnt", count, 3'd3);
        redirect = 1'b1;
        redirect_pc = 32'h0000_2002;
        #1;
        check("rd.req_r", imem_req, 1'b0);
        step();
        redirect = 1'b0;
        ready = 1'b1;
        #1;
        check("rd.valid1", valid, 1'b0);
        check("rd.cnt1", count, 3'd0);
        check("rd.req1", imem_req, 1'b1);
        check("rd.addr1", imem_addr, 32'h0000_2000);
        step();
        for (int d = 1; d < 5; d++) begin
            #1;
            expect_head($sformatf("rd.d%0d", d), d >= FIRST, 32'h0000_2000 + 32'(4 * (d - FIRST)));
            step();
        end

        // Back-to-back redirects: only the second path may be delivered
        redirect = 1'b1;
        redirect_pc = 32'h0000_0100;
        #1;
        check("bb.req_a", imem_req, 1'b0);
        step();
        redirect_pc = 32'h0000_0200;
        #1;
        check("bb.req_b", imem_req, 1'b0);
        check("bb.valid_b", valid, 1'b0);
        step();
        redirect = 1'b0;
        #1;
        check("bb.req", imem_req, 1'b1);
        check("bb.addr", imem_addr, 32'h0000_0200);
        check("bb.valid0", valid, 1'b0);
        step();
        for (int d = 1; d < 6; d++) begin
            #1;
            expect_head($sformatf("bb.d%0d", d), d >= FIRST, 32'h0000_0200 + 32'(4 * (d - FIRST)));
            step();
        end

        // Address wrap-around past the top of the address space
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        #1;
        step();
        redirect = 1'b0;
        #1;
        check("wr.addr0", imem_addr, 32'hFFFF_FFF8);
        step();
        for (int d = 1; d < 6; d++) begin
            #1;
            if (d == 2) check("wr.addr2", imem_addr, 32'h0000_0000);
            expect_head($sformatf("wr.d%0d", d), d >= FIRST, 32'hFFFF_FFF8 + 32'(4 * (d - FIRST)));
            step();
        end

        // Reset mid-stream with two entries queued
        ready = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) step();
        #1;
        check("mr.precnt", count, 3'd2);
        rst = 1'b1;
        #1;
        check("mr.req_r", imem_req, 1'b0);
        check("mr.valid_r", valid, 1'b0);
        check("mr.cnt_r", count, 3'd0);
        step();
        rst = 1'b0;
        ready = 1'b1;
        #1;
        check("mr.valid", valid, 1'b0);
        check("mr.cnt", count, 3'd0);
        check("mr.insn", insn, 32'h0);
        check("mr.pc", pc, 32'h0);
        check("mr.req", imem_req, 1'b1);
        check("mr.addr", imem_addr, RPC);
        step();
        for (int d = 1; d < 5; d++) begin
            #1;
            expect_head($sformatf("mr.d%0d", d), d >= FIRST, RPC + 32'(4 * (d - FIRST)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
